// File: rtl/sdram_cmd_scheduler.sv
// sdram_cmd_scheduler
// Single-bank-open SDRAM command scheduler. Every access follows the same
// closed-page cycle: ACTIVATE, READ/WRITE, then PRECHARGE ALL. Auto-refresh
// is requested every REF_PERIOD cycles and takes priority at the next IDLE.
// All outputs are registered, and the command for a state is on ocmd during
// that state's cycle.
// Optional feature: define SDRAM_SCHED_STATS_EN to get a saturating
// refresh-command counter on oref_count. Without it, oref_count is tied to 0.
module sdram_cmd_scheduler #(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned T_RCD      = 2,
  parameter int unsigned CAS_LAT    = 2,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 8
) (
  input  logic        iclk,
  input  logic        ctr_reset,
  input  logic        iinit_done,
  input  logic        ird_req,
  input  logic [23:0] ird_addr,
  input  logic        iwr_req,
  input  logic [23:0] iwr_addr,
  input  logic [15:0] iwr_data,
  output logic        ord_ack,
  output logic        owr_ack,
  output logic        ord_valid,
  output logic [15:0] ord_data,
  output logic        obusy,
  output logic        oref_miss,
  output logic [15:0] oref_count,
  output logic [3:0]  ocmd,
  output logic [12:0] oaddr,
  output logic [1:0]  oba,
  output logic [1:0]  odqm,
  output logic [15:0] odq_out,
  output logic        odq_oe,
  input  logic [15:0] idq_in
);

  localparam logic [3:0] S_WAIT_INIT = 4'd0;
  localparam logic [3:0] S_IDLE      = 4'd1;
  localparam logic [3:0] S_REFRESH   = 4'd2;
  localparam logic [3:0] S_REF_WAIT  = 4'd3;
  localparam logic [3:0] S_ACTIVATE  = 4'd4;
  localparam logic [3:0] S_RCD_WAIT  = 4'd5;
  localparam logic [3:0] S_WRITE     = 4'd6;
  localparam logic [3:0] S_READ      = 4'd7;
  localparam logic [3:0] S_CAS_WAIT  = 4'd8;
  localparam logic [3:0] S_PRECHARGE = 4'd9;
  localparam logic [3:0] S_RP_WAIT   = 4'd10;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  localparam int unsigned RCW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam logic [RCW-1:0] REF_LAST = RCW'(REF_PERIOD - 1);

  logic [3:0]     state, nxt_state;
  logic [7:0]     wait_cnt, nxt_cnt;
  logic [RCW-1:0] ref_cnt;
  logic           ref_pending;
  logic           ref_wrap;
  logic           ref_start;
  logic           last_wr;
  logic           grant_rd, grant_wr;
  logic [23:0]    sel_addr;

  logic           lat_is_rd;
  logic [1:0]     lat_bank;
  logic [8:0]     lat_col;
  logic [15:0]    lat_data;

  logic [3:0]     n_cmd;
  logic [12:0]    n_addr;
  logic [1:0]     n_ba;
  logic [1:0]     n_dqm;
  logic           n_oe;
  logic [15:0]    n_dq;
  logic           n_rd_ack, n_wr_ack, n_valid, n_busy;

  assign ref_wrap  = iinit_done && (ref_cnt == REF_LAST);
  assign ref_start = (state == S_IDLE) && (nxt_state == S_REFRESH);

  // Round-robin read/write arbitration; only meaningful in IDLE with no refresh due
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == S_IDLE && iinit_done && !ref_pending) begin
      if (ird_req && iwr_req) begin
        grant_rd = last_wr;
        grant_wr = !last_wr;
      end else begin
        grant_rd = ird_req;
        grant_wr = iwr_req;
      end
    end
    sel_addr = grant_rd ? ird_addr : iwr_addr;
  end

  // Next-state and wait-counter sequencing
  always_comb begin
    nxt_state = state;
    nxt_cnt   = wait_cnt;
    case (state)
      S_WAIT_INIT: if (iinit_done) nxt_state = S_IDLE;
      S_IDLE: begin
        if (!iinit_done)              nxt_state = S_WAIT_INIT;
        else if (ref_pending)         nxt_state = S_REFRESH;
        else if (grant_rd | grant_wr) nxt_state = S_ACTIVATE;
      end
      S_REFRESH: begin
        if (T_RFC > 1) begin
          nxt_state = S_REF_WAIT;
          nxt_cnt   = 8'(T_RFC - 2);
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_REF_WAIT: begin
        if (wait_cnt == 8'd0) nxt_state = S_IDLE;
        else                  nxt_cnt   = wait_cnt - 8'd1;
      end
      S_ACTIVATE: begin
        if (T_RCD > 1) begin
          nxt_state = S_RCD_WAIT;
          nxt_cnt   = 8'(T_RCD - 2);
        end else begin
          nxt_state = lat_is_rd ? S_READ : S_WRITE;
        end
      end
      S_RCD_WAIT: begin
        if (wait_cnt == 8'd0) nxt_state = lat_is_rd ? S_READ : S_WRITE;
        else                  nxt_cnt   = wait_cnt - 8'd1;
      end
      S_WRITE: nxt_state = S_PRECHARGE;
      S_READ: begin
        nxt_state = S_CAS_WAIT;
        nxt_cnt   = 8'(CAS_LAT - 1);
      end
      S_CAS_WAIT: begin
        if (wait_cnt == 8'd0) nxt_state = S_PRECHARGE;
        else                  nxt_cnt   = wait_cnt - 8'd1;
      end
      S_PRECHARGE: begin
        if (T_RP > 1) begin
          nxt_state = S_RP_WAIT;
          nxt_cnt   = 8'(T_RP - 2);
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_RP_WAIT: begin
        if (wait_cnt == 8'd0) nxt_state = S_IDLE;
        else                  nxt_cnt   = wait_cnt - 8'd1;
      end
      default: nxt_state = S_WAIT_INIT;
    endcase
  end

  // Pin values for the state being entered, so they are registered with it
  always_comb begin
    n_cmd    = CMD_NOP;
    n_addr   = '0;
    n_ba     = '0;
    n_dqm    = 2'b11;
    n_oe     = 1'b0;
    n_dq     = '0;
    n_rd_ack = 1'b0;
    n_wr_ack = 1'b0;
    n_busy   = (nxt_state != S_IDLE);
    // Data is due CAS_LAT cycles after READ: capture on the edge that ends
    // the next-to-last CAS_WAIT cycle.
    n_valid  = (state == S_CAS_WAIT) && (wait_cnt == 8'd1);
    case (nxt_state)
      S_REFRESH: n_cmd = CMD_REF;
      S_ACTIVATE: begin
        n_cmd    = CMD_ACT;
        n_ba     = sel_addr[23:22];
        n_addr   = sel_addr[21:9];
        n_rd_ack = grant_rd;
        n_wr_ack = grant_wr;
      end
      S_WRITE: begin
        n_cmd  = CMD_WR;
        n_ba   = lat_bank;
        n_addr = {4'b0000, lat_col};
        n_dqm  = 2'b00;
        n_oe   = 1'b1;
        n_dq   = lat_data;
      end
      S_READ: begin
        n_cmd  = CMD_RD;
        n_ba   = lat_bank;
        n_addr = {4'b0000, lat_col};
        n_dqm  = 2'b00;
      end
      S_PRECHARGE: begin
        n_cmd  = CMD_PRE;
        n_addr = 13'h0400;
      end
      default: ;
    endcase
  end

  // State, wait counter and registered pin outputs
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state     <= S_WAIT_INIT;
      wait_cnt  <= '0;
      ocmd      <= CMD_NOP;
      oaddr     <= '0;
      oba       <= '0;
      odqm      <= '1;
      odq_oe    <= 1'b0;
      odq_out   <= '0;
      ord_ack   <= 1'b0;
      owr_ack   <= 1'b0;
      ord_valid <= 1'b0;
      ord_data  <= '0;
      obusy     <= 1'b1;
    end else begin
      state     <= nxt_state;
      wait_cnt  <= nxt_cnt;
      ocmd      <= n_cmd;
      oaddr     <= n_addr;
      oba       <= n_ba;
      odqm      <= n_dqm;
      odq_oe    <= n_oe;
      odq_out   <= n_dq;
      ord_ack   <= n_rd_ack;
      owr_ack   <= n_wr_ack;
      ord_valid <= n_valid;
      obusy     <= n_busy;
      if (n_valid) ord_data <= idq_in;
    end
  end

  // Capture the granted request and remember which side was served
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      lat_is_rd <= 1'b0;
      lat_bank  <= '0;
      lat_col   <= '0;
      lat_data  <= '0;
      last_wr   <= 1'b1;
    end else if (grant_rd | grant_wr) begin
      lat_is_rd <= grant_rd;
      lat_bank  <= sel_addr[23:22];
      lat_col   <= sel_addr[8:0];
      lat_data  <= iwr_data;
      last_wr   <= grant_wr;
    end
  end

  // Refresh interval timer, pending flag and sticky overrun flag
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      oref_miss   <= 1'b0;
    end else begin
      if (iinit_done) begin
        if (ref_wrap) ref_cnt <= '0;
        else          ref_cnt <= ref_cnt + RCW'(1);
      end
      // A wrap on the very edge a refresh is issued is not an overrun.
      if (ref_wrap && ref_pending && !ref_start) oref_miss <= 1'b1;
      if (ref_wrap)       ref_pending <= 1'b1;
      else if (ref_start) ref_pending <= 1'b0;
    end
  end

`ifdef SDRAM_SCHED_STATS_EN
  // Saturating count of REFRESH commands issued
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset)
      oref_count <= '0;
    else if (ref_start && oref_count != 16'hFFFF)
      oref_count <= oref_count + 16'd1;
  end
`else
  assign oref_count = '0;
`endif

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Bench for sdram_cmd_scheduler: directed and randomized requests against a
// transaction-level model that expands each grant into its expected command
// timeline (from the timing parameters) and compares the pins every cycle.
module tb_sdram_cmd_scheduler;

  localparam int REF_P = 20;
  localparam int RCD   = 2;
  localparam int CL    = 2;
  localparam int RP    = 2;
  localparam int RFC   = 8;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  localparam int K_IDLE = 0;
  localparam int K_INIT = 1;
  localparam int K_BUSY = 2;

  logic        iclk = 1'b0;
  logic        ctr_reset, iinit_done, ird_req, iwr_req;
  logic [23:0] ird_addr, iwr_addr;
  logic [15:0] iwr_data, idq_in;
  logic        ord_ack, owr_ack, ord_valid, obusy, oref_miss, odq_oe;
  logic [15:0] ord_data, oref_count, odq_out;
  logic [3:0]  ocmd;
  logic [12:0] oaddr;
  logic [1:0]  oba, odqm;

  sdram_cmd_scheduler #(
    .REF_PERIOD(REF_P), .T_RCD(RCD), .CAS_LAT(CL), .T_RP(RP), .T_RFC(RFC)
  ) dut (
    .iclk(iclk), .ctr_reset(ctr_reset), .iinit_done(iinit_done),
    .ird_req(ird_req), .ird_addr(ird_addr), .iwr_req(iwr_req),
    .iwr_addr(iwr_addr), .iwr_data(iwr_data),
    .ord_ack(ord_ack), .owr_ack(owr_ack), .ord_valid(ord_valid),
    .ord_data(ord_data), .obusy(obusy), .oref_miss(oref_miss),
    .oref_count(oref_count), .ocmd(ocmd), .oaddr(oaddr), .oba(oba),
    .odqm(odqm), .odq_out(odq_out), .odq_oe(odq_oe), .idq_in(idq_in)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int          kind;
    logic [3:0]  cmd;
    logic        chk_a;
    logic        chk_ba;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic        oe;
    logic        chk_dq;
    logic [15:0] dq;
    logic        rack;
    logic        wack;
    logic        valid;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int unsigned edges;
  bit          pend, m_miss, last_wr;
  int unsigned m_refs;
  logic [15:0] exp_rdata;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic exp_t rec(int kind, logic [3:0] cmd);
    exp_t r;
    r.kind = kind; r.cmd = cmd; r.chk_a = 1'b0; r.chk_ba = 1'b0;
    r.addr = '0; r.ba = '0; r.dqm = 2'b11; r.oe = 1'b0; r.chk_dq = 1'b0;
    r.dq = '0; r.rack = 1'b0; r.wack = 1'b0; r.valid = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef SDRAM_SCHED_STATS_EN
    return (m_refs > 32'hFFFF) ? 16'hFFFF : m_refs[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_cur();
    chk("ocmd", {28'd0, ocmd}, {28'd0, cur.cmd});
    chk("obusy", {31'd0, obusy}, {31'd0, (cur.kind != K_IDLE)});
    chk("odqm", {30'd0, odqm}, {30'd0, cur.dqm});
    chk("odq_oe", {31'd0, odq_oe}, {31'd0, cur.oe});
    chk("ord_ack", {31'd0, ord_ack}, {31'd0, cur.rack});
    chk("owr_ack", {31'd0, owr_ack}, {31'd0, cur.wack});
    chk("ord_valid", {31'd0, ord_valid}, {31'd0, cur.valid});
    chk("oref_miss", {31'd0, oref_miss}, {31'd0, m_miss});
    chk("oref_count", {16'd0, oref_count}, {16'd0, exp_count()});
    if (cur.chk_a)  chk("oaddr", {19'd0, oaddr}, {19'd0, cur.addr});
    if (cur.chk_ba) chk("oba", {30'd0, oba}, {30'd0, cur.ba});
    if (cur.chk_dq) chk("odq_out", {16'd0, odq_out}, {16'd0, cur.dq});
    if (cur.valid)  chk("ord_data", {16'd0, ord_data}, {16'd0, exp_rdata});
  endtask

  task automatic push_refresh();
    q.push_back(rec(K_BUSY, C_REF));
    for (int i = 1; i < RFC; i++) q.push_back(rec(K_BUSY, C_NOP));
  endtask

  task automatic push_access(input bit is_rd, input logic [23:0] a, input logic [15:0] d);
    exp_t r;
    r = rec(K_BUSY, C_ACT);
    r.chk_a = 1'b1; r.chk_ba = 1'b1; r.ba = a[23:22]; r.addr = a[21:9];
    r.rack = is_rd; r.wack = !is_rd;
    q.push_back(r);
    for (int i = 1; i < RCD; i++) q.push_back(rec(K_BUSY, C_NOP));
    r = rec(K_BUSY, is_rd ? C_RD : C_WR);
    r.chk_a = 1'b1; r.chk_ba = 1'b1; r.ba = a[23:22]; r.addr = {4'b0000, a[8:0]};
    r.dqm = 2'b00;
    if (!is_rd) begin r.oe = 1'b1; r.chk_dq = 1'b1; r.dq = d; end
    q.push_back(r);
    if (is_rd) begin
      for (int i = 1; i < CL; i++) q.push_back(rec(K_BUSY, C_NOP));
      r = rec(K_BUSY, C_NOP); r.valid = 1'b1;
      q.push_back(r);
    end
    r = rec(K_BUSY, C_PRE); r.chk_a = 1'b1; r.addr = 13'h0400;
    q.push_back(r);
    for (int i = 1; i < RP; i++) q.push_back(rec(K_BUSY, C_NOP));
  endtask

  task automatic model_reset();
    q.delete();
    cur = rec(K_INIT, C_NOP);
    edges = 0; pend = 1'b0; m_miss = 1'b0; last_wr = 1'b1; m_refs = 0;
    exp_rdata = '0;
  endtask

  // One clock: predict the next cycle from the current inputs, then compare.
  task automatic tick();
    exp_t nxt;
    bit   wrap = 1'b0;
    bit   served = 1'b0;
    bit   pick_rd;
    if (iinit_done) begin
      edges++;
      wrap = (edges % REF_P) == 0;
    end
    if (q.size() > 0) begin
      nxt = q.pop_front();
    end else if (cur.kind == K_INIT) begin
      nxt = iinit_done ? rec(K_IDLE, C_NOP) : rec(K_INIT, C_NOP);
    end else if (cur.kind == K_BUSY) begin
      nxt = rec(K_IDLE, C_NOP);
    end else if (!iinit_done) begin
      nxt = rec(K_INIT, C_NOP);
    end else if (pend) begin
      served = 1'b1;
      push_refresh();
      nxt = q.pop_front();
    end else if (ird_req || iwr_req) begin
      pick_rd = (ird_req && iwr_req) ? last_wr : ird_req;
      last_wr = !pick_rd;
      push_access(pick_rd, pick_rd ? ird_addr : iwr_addr, iwr_data);
      nxt = q.pop_front();
    end else begin
      nxt = rec(K_IDLE, C_NOP);
    end
    if (wrap && pend && !served) m_miss = 1'b1;
    if (wrap)        pend = 1'b1;
    else if (served) pend = 1'b0;
    if (nxt.cmd == C_REF) m_refs++;
    if (nxt.valid) exp_rdata = idq_in;
    @(posedge iclk);
    #1;
    cur = nxt;
    check_cur();
    idq_in = 16'($urandom);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded: advance until the model says the scheduler is idle.
  task automatic wait_idle();
    for (int i = 0; i < 40 && cur.kind != K_IDLE; i++) tick();
    chk("wait_idle", {31'd0, (cur.kind == K_IDLE)}, 32'd1);
  endtask

  task automatic check_reset_pins();
    chk("rst_ocmd", {28'd0, ocmd}, {28'd0, C_NOP});
    chk("rst_oaddr", {19'd0, oaddr}, 32'd0);
    chk("rst_oba", {30'd0, oba}, 32'd0);
    chk("rst_odqm", {30'd0, odqm}, 32'd3);
    chk("rst_odq_oe", {31'd0, odq_oe}, 32'd0);
    chk("rst_odq_out", {16'd0, odq_out}, 32'd0);
    chk("rst_ord_data", {16'd0, ord_data}, 32'd0);
    chk("rst_acks", {30'd0, ord_ack, owr_ack}, 32'd0);
    chk("rst_valid", {31'd0, ord_valid}, 32'd0);
    chk("rst_obusy", {31'd0, obusy}, 32'd1);
    chk("rst_miss", {31'd0, oref_miss}, 32'd0);
    chk("rst_count", {16'd0, oref_count}, 32'd0);
  endtask

  initial begin
    ctr_reset = 1'b1; iinit_done = 1'b0; ird_req = 1'b0; iwr_req = 1'b0;
    ird_addr = '0; iwr_addr = '0; iwr_data = '0; idq_in = 16'h1234;
    model_reset();
    repeat (2) @(posedge iclk);
    #1;
    check_reset_pins();
    ctr_reset = 1'b0;

    // Stay in WAIT_INIT until init completes
    ticks(3);
    iinit_done = 1'b1;
    tick();

    // Single read 24'h4A_0123
    ird_addr = 24'h4A_0123; ird_req = 1'b1;
    tick();
    ird_req = 1'b0;
    ticks(8);

    // Single write with 16'hBEEF
    wait_idle();
    iwr_addr = 24'hC1_2345; iwr_data = 16'hBEEF; iwr_req = 1'b1;
    tick();
    iwr_req = 1'b0;
    ticks(6);

    // Both held: alternation, refresh interleave, back-to-back stream
    ird_req = 1'b1; iwr_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ird_addr = 24'($urandom); iwr_addr = 24'($urandom); iwr_data = 16'($urandom);
      tick();
    end
    ird_req = 1'b0; iwr_req = 1'b0;

    // Randomized traffic with occasional init drops
    for (int i = 0; i < 700; i++) begin
      ird_req    = ($urandom_range(0, 2) == 0);
      iwr_req    = ($urandom_range(0, 2) == 0);
      ird_addr   = 24'($urandom);
      iwr_addr   = 24'($urandom);
      iwr_data   = 16'($urandom);
      iinit_done = ($urandom_range(0, 40) != 0);
      tick();
    end
    ird_req = 1'b0; iwr_req = 1'b0; iinit_done = 1'b1;
    wait_idle();

    // Reset while in RCD_WAIT abandons the read
    ird_addr = 24'h12_3456; ird_req = 1'b1;
    tick();
    ird_req = 1'b0;
    tick();
    ctr_reset = 1'b1;
    #1;
    model_reset();
    check_reset_pins();
    @(posedge iclk);
    #1;
    check_reset_pins();
    ctr_reset = 1'b0;
    ticks(8);

    // Idle long enough for exactly three refreshes
    ticks(62);
`ifdef SDRAM_SCHED_STATS_EN
    chk("refresh_count_3", {16'd0, oref_count}, 32'd3);
`else
    chk("refresh_count_off", {16'd0, oref_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
